priority_arbiter4: RTL and testbench



---
 rtl/priority_arbiter4.sv | 127 ++++++++++++
 tb/tb_priority_arbiter4.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/priority_arbiter4.sv
// Four-requester priority arbiter with round-robin tie-break, hold-time limit
// and registered one-hot grant.
module priority_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [7:0] prio,
    output logic [3:0] grant,
    output logic [1:0] owner,
    output logic       busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

    state_t     state_r;
    logic [7:0] hcnt_r;
    logic [1:0] last_r;

    logic [3:0] others_s;
    logic [3:0] cand_s;
    logic [1:0] winner_s;
    logic       take_s;
    logic       drop_s;
    logic       hold_s;

    // Scan from last+1 onward; strict '>' keeps the first tied candidate in scan order.
    function automatic logic [1:0] pick_winner(input logic [3:0] cand,
                                               input logic [7:0] pr,
                                               input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] best_idx;
        logic [1:0] best_pr;
        logic       found;
        best_idx = last;
        best_pr  = 2'd0;
        found    = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (cand[idx] && (!found || (pr[{idx, 1'b0} +: 2] > best_pr))) begin
                found    = 1'b1;
                best_idx = idx;
                best_pr  = pr[{idx, 1'b0} +: 2];
            end else begin
                found    = found;
            end
        end
        return best_idx;
    endfunction

    // Candidate set: everyone from idle, everyone except the owner on a handover.
    always_comb begin
        others_s = req & ~(4'b0001 << owner);
        if (state_r == ST_IDLE) begin
            cand_s = req;
        end else begin
            cand_s = others_s;
        end
        winner_s = pick_winner(cand_s, prio, last_r);
    end

    // Decide this edge's action: new grant, release to idle, or keep holding.
    always_comb begin
        take_s = 1'b0;
        drop_s = 1'b0;
        hold_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    take_s = 1'b1;
                end else begin
                    take_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (!req[owner]) begin
                    if (others_s != 4'b0000) begin
                        take_s = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                end else if ((hcnt_r >= HOLD_MAX) && (others_s != 4'b0000)) begin
                    take_s = 1'b1;
                end else begin
                    hold_s = 1'b1;
                end
            end
            default: begin
                drop_s = 1'b1;
            end
        endcase
    end

    // Arbiter state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            grant   <= 4'b0000;
            owner   <= 2'd0;
            busy    <= 1'b0;
            hcnt_r  <= 8'd0;
            last_r  <= 2'd3;
        end else if (take_s) begin
            state_r <= ST_GRANT;
            grant   <= 4'b0001 << winner_s;
            owner   <= winner_s;
            busy    <= 1'b1;
            hcnt_r  <= 8'd1;
            last_r  <= winner_s;
        end else if (drop_s) begin
            state_r <= ST_IDLE;
            grant   <= 4'b0000;
            busy    <= 1'b0;
        end else if (hold_s) begin
            hcnt_r  <= (hcnt_r < HOLD_MAX) ? (hcnt_r + 8'd1) : hcnt_r;
        end else begin
            hcnt_r  <= hcnt_r;
        end
    end

endmodule

// File: tb/tb_priority_arbiter4.sv
// Self-checking bench for priority_arbiter4: directed test-plan scenarios
// followed by randomized traffic against a rule-level reference model.
module tb_priority_arbiter4;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [7:0] prio = 8'd0;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_active;
    int m_owner;
    int m_last;
    int m_hcnt;

    priority_arbiter4 #(.MAX_HOLD(MH)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .prio (prio),
        .grant(grant),
        .owner(owner),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Highest priority first, then first in rotation order after 'last'.
    function automatic int arb(input logic [3:0] c, input logic [7:0] p, input int last);
        int best;
        int idx;
        best = -1;
        for (int i = 0; i < 4; i++)
            if (c[i] && int'(p[2*i +: 2]) > best) best = int'(p[2*i +: 2]);
        for (int k = 1; k <= 4; k++) begin
            idx = (last + k) % 4;
            if (c[idx] && int'(p[2*idx +: 2]) == best) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_owner  = 0;
        m_last   = 3;
        m_hcnt   = 0;
    endtask

    task automatic model_give(input int w);
        m_active = 1'b1;
        m_owner  = w;
        m_last   = w;
        m_hcnt   = 1;
    endtask

    task automatic model_edge();
        logic [3:0] oth;
        if (!m_active) begin
            if (req != 4'b0000) model_give(arb(req, prio, m_last));
        end else begin
            oth = req;
            oth[m_owner] = 1'b0;
            if (!req[m_owner]) begin
                if (oth != 4'b0000) model_give(arb(oth, prio, m_last));
                else m_active = 1'b0;
            end else if (m_hcnt == MH && oth != 4'b0000) begin
                model_give(arb(oth, prio, m_last));
            end else if (m_hcnt < MH) begin
                m_hcnt++;
            end
        end
    endtask

    task automatic compare_model(input string tag);
        logic [3:0] eg;
        eg = m_active ? (4'b0001 << m_owner) : 4'b0000;
        check_eq({tag, "_grant"}, 32'(grant), 32'(eg));
        check_eq({tag, "_owner"}, 32'(owner), 32'(m_owner));
        check_eq({tag, "_busy"},  32'(busy),  32'(m_active));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_model(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_eq({tag, "_grant"}, 32'(grant), 32'd0);
        check_eq({tag, "_busy"},  32'(busy),  32'd0);
        check_eq({tag, "_owner"}, 32'(owner), 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        // Reset with all requests asserted
        req = 4'b1111;
        #12;
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_busy",  32'(busy),  32'd0);
        check_eq("rst_owner", 32'(owner), 32'd0);
        req = 4'b0000;
        rst = 1'b1;
        step("idle0");
        step("idle1");

        // Single request, no preemption, gapless handover
        req = 4'b0100;
        step("single");
        check_eq("single_const", 32'(grant), 32'h4);
        req  = 4'b0101;
        prio = 8'b00_00_00_11;
        step("nopre0");
        step("nopre1");
        check_eq("nopre_const", 32'(grant), 32'h4);
        req = 4'b0001;
        step("handover");
        check_eq("handover_const", 32'(grant), 32'h1);

        // Priority select from idle
        req = 4'b0000;
        step("toidle");
        prio = 8'b11_00_01_10;
        req  = 4'b1011;
        step("priosel");
        check_eq("priosel_const", 32'(grant), 32'h8);

        // Equal-priority round robin
        req = 4'b0000;
        step("toidle2");
        prio = 8'd0;
        req  = 4'b1111;
        step("rr0");
        check_eq("rr0_const", 32'(grant), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            logic [3:0] exp_rr;
            exp_rr = 4'b0001 << (i % 4);
            req = 4'b1111 & ~grant;
            step("rr");
            check_eq("rr_const", 32'(grant), 32'(exp_rr));
            req = 4'b1111;
            step("rr_hold");
        end

        // Timeout with MAX_HOLD = 4
        req = 4'b0000;
        step("toidle3");
        prio = 8'b00_00_11_00;
        req  = 4'b1010;
        for (int i = 0; i < MH; i++) begin
            step("to_hold");
            check_eq("to_hold_const", 32'(grant), 32'h2);
        end
        step("to_move");
        check_eq("to_move_const", 32'(grant), 32'h8);
        req = 4'b0010;
        step("to_back");
        check_eq("to_back_const", 32'(grant), 32'h2);
        for (int i = 0; i < 22; i++) step("uncont");
        check_eq("uncont_const", 32'(grant), 32'h2);

        // Reset mid-grant, then equal-priority arbitration from idle
        async_reset("midrst");
        prio = 8'd0;
        req  = 4'b1010;
        step("postrst");
        check_eq("postrst_const", 32'(grant), 32'h2);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) prio = 8'($urandom);
            if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
